fibo_controller: RTL and testbench
==================================

Name: fibo_controller

Overview:
- Control FSM that drives FIBO_DATAPATH. It sequences register loads, ALU operations and register-file writes so the datapath computes Fib(N) for an N supplied at start.
- Sits beside the datapath and consumes its zero_flag. Its outputs connect one-to-one to the datapath's control inputs.
- Register map, fixed:
  - R0 = F(i)
  - R1 = F(i+1)
  - R2 = iterations remaining
  - R3 = constant 1

Parameters:
- size, 4: datapath word width; width of N and count.
- OP_PASSA, 3'b000: ALU opcode, result = A.
- OP_ADD, 3'b001: ALU opcode, result = A + B mod 2^size.
- OP_SUB, 3'b010: ALU opcode, result = A - B mod 2^size.

Ports:
- Clk  in  1  clock. Controller acts on rising edge; datapath result register captures on falling edge.
- Rst  in  1  synchronous, active-high reset.
- start  in  1  level request; sampled only in IDLE.
- n_in  in  size  Fibonacci index N; captured when start is sampled in IDLE.
- zero_flag  in  1  from datapath; 1 iff the current ALU result == 0.
- wrt_en  out  1  register-file write enable.
- wrt_adder  out  2  register-file write address.
- load_data  out  1  1 = write count, 0 = write data_out.
- count  out  size  constant/load value driven into the datapath.
- rd_addr1  out  2  ALU operand A select.
- rd_addr2  out  2  ALU operand B select.
- alu_opcode  out  3  ALU operation.
- busy  out  1  1 in any state other than IDLE and DONE.
- done  out  1  1 in DONE only.

Behaviour:
- All outputs are Moore, decoded from the state register. Internal register n_q holds N.
- Datapath timing per cycle:
  - Controller drives reads and opcode; the ALU evaluates.
  - On the falling edge, data_out captures the ALU result.
  - On the next rising edge, if wrt_en=1, register wrt_adder <= (load_data ? count : data_out).
  - Every ALU op plus writeback completes in one cycle.
- Defaults in every state unless listed: wrt_en=0, load_data=0, count=0, rd_addr1=0, rd_addr2=0, alu_opcode=OP_PASSA.
- States and transitions:
  - IDLE: if start=1, n_q <= n_in and go to INIT0.
  - INIT0: load count=0 into R0 (wrt_en=1, load_data=1, wrt_adder=0).
  - INIT1: load count=1 into R1.
  - INIT2: load count=1 into R3.
  - INIT3: load count=n_q into R2; go to CHECK.
  - CHECK: rd_addr1=2, OP_PASSA, no write. If zero_flag=1 go to DONE, else go to ADD.
  - ADD: rd_addr1=0, rd_addr2=1, OP_ADD, write R1 (R1 <= R0+R1).
  - SUB: rd_addr1=1, rd_addr2=0, OP_SUB, write R0 (R0 <= newR1-R0 = old R1).
  - DEC: rd_addr1=2, rd_addr2=3, OP_SUB, write R2; go to CHECK.
  - DONE: rd_addr1=0, OP_PASSA, no write, done=1. Stay while start=1; go to IDLE when start=0.
- The IDLE read/opcode defaults keep data_out = R0, so the result stays visible after done falls.
- Latency: done rises 4N+5 rising edges after the edge that samples start in IDLE. For N=0 that is 5.
- data_out is valid from the falling edge inside the first DONE cycle. It is stable at every rising edge where done=1.
- Arithmetic is mod 2^size. The ADD/SUB pair is exact in the modular ring, so the result is Fib(N) mod 2^size with no overflow detection.
- Boundaries:
  - start is ignored outside IDLE.
  - zero_flag is qualified only in CHECK.
  - N=0 skips the loop entirely.
  - N = 2^size-1 runs the full loop with no early exit.
- Reset:
  - Reset wins over every transition: state <= IDLE, n_q <= 0, outputs take IDLE values, done=0, busy=0.
  - Mid-run reset aborts the run; datapath register contents are left as-is.
  - The next run re-initialises all four registers.
- The controller never writes in CHECK or DONE, and never writes two registers in one cycle.

Test Plan:
- N=0, start pulse held: done at edge 5, data_out=0, busy high for edges 1-4. No write after INIT3.
- N=1: done at edge 9, data_out=1. Write trace is R0=0, R1=1, R3=1, R2=1, R1=1, R0=1, R2=0.
- N=7, size=4: done at edge 33, data_out=13. R2 decrements 7→0.
- N=8, size=4: done at edge 37, data_out=5 (21 mod 16).
- Mid-run reset: N=7, assert Rst at edge 12. Then busy=0, done=0, state IDLE. A new start with N=5 gives done at edge 25 and data_out=5.
- Handshake: hold start through DONE; done stays 1 and no new run starts. Drop start, then raise it with N=2 → data_out=1. Toggling n_in while busy does not alter the result.

Source files
------------

// File: rtl/fibo_controller.sv
// fibo_controller
//   Moore control FSM that sequences a small register-file/ALU datapath so it
//   computes Fib(N) mod 2^size. The register roles are fixed:
//   R0 = F(i), R1 = F(i+1), R2 = iterations remaining, R3 = constant 1.
//
// Ports
//   Clk        : clock. The FSM advances on the rising edge.
//   Rst        : synchronous active-high reset.
//   start      : level request. Only looked at in IDLE.
//   n_in       : Fibonacci index N. Captured together with start.
//   zero_flag  : datapath flag. High when the ALU result is zero.
//   wrt_en     : register-file write enable.
//   wrt_adder  : register-file write address.
//   load_data  : write-source select (1 = count, 0 = datapath data_out).
//   count      : constant or load value presented to the datapath.
//   rd_addr1   : ALU operand A select.
//   rd_addr2   : ALU operand B select.
//   alu_opcode : ALU operation.
//   busy       : high in every state except IDLE and DONE.
//   done       : high in DONE only.
module fibo_controller #(
  parameter int          size     = 4,
  parameter logic [2:0]  OP_PASSA = 3'b000,
  parameter logic [2:0]  OP_ADD   = 3'b001,
  parameter logic [2:0]  OP_SUB   = 3'b010
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic            start,
  input  logic [size-1:0] n_in,
  input  logic            zero_flag,
  output logic            wrt_en,
  output logic [1:0]      wrt_adder,
  output logic            load_data,
  output logic [size-1:0] count,
  output logic [1:0]      rd_addr1,
  output logic [1:0]      rd_addr2,
  output logic [2:0]      alu_opcode,
  output logic            busy,
  output logic            done
);

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    INIT0 = 4'd1,
    INIT1 = 4'd2,
    INIT2 = 4'd3,
    INIT3 = 4'd4,
    CHECK = 4'd5,
    ADD   = 4'd6,
    SUB   = 4'd7,
    DEC   = 4'd8,
    DONE  = 4'd9
  } state_t;

  localparam logic [size-1:0] ONE = {{(size-1){1'b0}}, 1'b1};

  state_t          state, state_nxt;
  logic [size-1:0] n_q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
      n_q   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start)
        n_q <= n_in;
    end
  end

  always_comb begin
    state_nxt  = state;
    wrt_en     = 1'b0;
    wrt_adder  = 2'd0;
    load_data  = 1'b0;
    count      = '0;
    rd_addr1   = 2'd0;
    rd_addr2   = 2'd0;
    alu_opcode = OP_PASSA;
    busy       = 1'b1;
    done       = 1'b0;

    unique case (state)
      IDLE: begin
        // PASSA of R0 keeps the last result on data_out after done falls.
        busy = 1'b0;
        if (start) state_nxt = INIT0;
      end
      INIT0: begin
        wrt_en    = 1'b1;
        load_data = 1'b1;
        wrt_adder = 2'd0;
        count     = '0;
        state_nxt = INIT1;
      end
      INIT1: begin
        wrt_en    = 1'b1;
        load_data = 1'b1;
        wrt_adder = 2'd1;
        count     = ONE;
        state_nxt = INIT2;
      end
      INIT2: begin
        wrt_en    = 1'b1;
        load_data = 1'b1;
        wrt_adder = 2'd3;
        count     = ONE;
        state_nxt = INIT3;
      end
      INIT3: begin
        wrt_en    = 1'b1;
        load_data = 1'b1;
        wrt_adder = 2'd2;
        count     = n_q;
        state_nxt = CHECK;
      end
      CHECK: begin
        // Pass R2 through the ALU so zero_flag reports "no iterations left".
        rd_addr1 = 2'd2;
        if (zero_flag) state_nxt = DONE;
        else           state_nxt = ADD;
      end
      ADD: begin
        rd_addr1   = 2'd0;
        rd_addr2   = 2'd1;
        alu_opcode = OP_ADD;
        wrt_en     = 1'b1;
        wrt_adder  = 2'd1;
        state_nxt  = SUB;
      end
      SUB: begin
        // new R1 - R0 recovers the old R1 exactly, even after wrap-around.
        rd_addr1   = 2'd1;
        rd_addr2   = 2'd0;
        alu_opcode = OP_SUB;
        wrt_en     = 1'b1;
        wrt_adder  = 2'd0;
        state_nxt  = DEC;
      end
      DEC: begin
        rd_addr1   = 2'd2;
        rd_addr2   = 2'd3;
        alu_opcode = OP_SUB;
        wrt_en     = 1'b1;
        wrt_adder  = 2'd2;
        state_nxt  = CHECK;
      end
      DONE: begin
        rd_addr1 = 2'd0;
        busy     = 1'b0;
        done     = 1'b1;
        if (!start) state_nxt = IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fibo_controller.sv
// Testbench for fibo_controller. A behavioural model of the register-file /
// ALU datapath closes the loop so the controller computes real results.
module tb_fibo_controller;

  localparam int SIZE = 4;

  logic            Clk = 1'b0;
  logic            Rst;
  logic            start;
  logic [SIZE-1:0] n_in;
  logic            zero_flag;
  logic            wrt_en;
  logic [1:0]      wrt_adder;
  logic            load_data;
  logic [SIZE-1:0] count;
  logic [1:0]      rd_addr1;
  logic [1:0]      rd_addr2;
  logic [2:0]      alu_opcode;
  logic            busy;
  logic            done;

  int errors = 0;
  int checks = 0;

  fibo_controller #(.size(SIZE)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .start      (start),
    .n_in       (n_in),
    .zero_flag  (zero_flag),
    .wrt_en     (wrt_en),
    .wrt_adder  (wrt_adder),
    .load_data  (load_data),
    .count      (count),
    .rd_addr1   (rd_addr1),
    .rd_addr2   (rd_addr2),
    .alu_opcode (alu_opcode),
    .busy       (busy),
    .done       (done)
  );

  always #5 Clk = ~Clk;

  // Datapath model: combinational ALU, data_out on falling edge,
  // register-file write on rising edge.
  logic [SIZE-1:0] rf [4];
  logic [SIZE-1:0] alu_a, alu_b, alu_res, data_out;
  int              wlog_addr[$];
  int              wlog_val[$];

  always_comb begin
    alu_a = rf[rd_addr1];
    alu_b = rf[rd_addr2];
    case (alu_opcode)
      3'b001:  alu_res = alu_a + alu_b;
      3'b010:  alu_res = alu_a - alu_b;
      default: alu_res = alu_a;
    endcase
  end
  assign zero_flag = (alu_res == '0);

  always @(negedge Clk) data_out <= alu_res;

  always @(posedge Clk) begin
    if (wrt_en) begin
      rf[wrt_adder] <= load_data ? count : data_out;
      wlog_addr.push_back(int'(wrt_adder));
      wlog_val.push_back(int'(load_data ? count : data_out));
    end
  end

  // Starts a run with N=n and waits for done. Edge 0 is the edge that
  // samples start; edges is the index of the edge after which done is
  // seen, or -1 if the bound expires. start stays high on return.
  task automatic do_run(input logic [SIZE-1:0] n, input bit wiggle_n,
                        output int edges);
    @(negedge Clk);
    start = 1'b1;
    n_in  = n;
    wlog_addr.delete();
    wlog_val.delete();
    @(posedge Clk);
    edges = -1;
    for (int k = 1; k <= 200; k++) begin
      @(posedge Clk);
      #1;
      if (wiggle_n) n_in = SIZE'($urandom);
      if (done) begin
        edges = k;
        break;
      end
    end
  endtask

  task automatic finish_run();
    @(negedge Clk);
    start = 1'b0;
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Rst   = 1'b1;
    start = 1'b1;
    n_in  = 4'd3;
    for (int i = 0; i < 4; i++) rf[i] = 4'hA;
    repeat (3) @(posedge Clk);
    #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: done=%b busy=%b, required done=0 busy=0", done, busy);
    end
    checks++;
    if (wrt_en !== 1'b0 || alu_opcode !== 3'b000 || rd_addr1 !== 2'd0) begin
      errors++;
      $display("FAIL reset_outputs: wrt_en=%b opcode=%0d rd1=%0d, required 0/0/0",
               wrt_en, alu_opcode, rd_addr1);
    end
    @(negedge Clk);
    start = 1'b0;
    Rst   = 1'b0;
  endtask

  task automatic test_n0();
    int edges;
    int busy_ok = 1;
    @(negedge Clk);
    start = 1'b1;
    n_in  = 4'd0;
    wlog_addr.delete();
    wlog_val.delete();
    @(posedge Clk);
    edges = -1;
    for (int k = 1; k <= 50; k++) begin
      @(posedge Clk);
      #1;
      if (k <= 4 && busy !== 1'b1) busy_ok = 0;
      if (done) begin
        edges = k;
        break;
      end
    end
    checks++;
    if (edges != 5) begin
      errors++;
      $display("FAIL n0_latency: got %0d edges, required 5", edges);
    end
    checks++;
    if (busy_ok != 1) begin
      errors++;
      $display("FAIL n0_busy: busy dropped during edges 1-4, required high");
    end
    @(negedge Clk);
    #1;
    checks++;
    if (data_out !== 4'd0) begin
      errors++;
      $display("FAIL n0_result: data_out=%0d, required 0", data_out);
    end
    repeat (3) @(posedge Clk);
    #1;
    checks++;
    if (wlog_addr.size() != 4 || done !== 1'b1) begin
      errors++;
      $display("FAIL n0_writes: writes=%0d done=%b, required 4 writes and done=1",
               wlog_addr.size(), done);
    end
    finish_run();
  endtask

  task automatic test_n1_trace();
    int edges;
    int exp_a[7] = '{0, 1, 3, 2, 1, 0, 2};
    int exp_v[7] = '{0, 1, 1, 1, 1, 1, 0};
    int trace_ok = 1;
    do_run(4'd1, 1'b0, edges);
    checks++;
    if (edges != 9) begin
      errors++;
      $display("FAIL n1_latency: got %0d edges, required 9", edges);
    end
    @(negedge Clk);
    #1;
    checks++;
    if (data_out !== 4'd1) begin
      errors++;
      $display("FAIL n1_result: data_out=%0d, required 1", data_out);
    end
    if (wlog_addr.size() != 7) trace_ok = 0;
    else
      for (int i = 0; i < 7; i++)
        if (wlog_addr[i] != exp_a[i] || wlog_val[i] != exp_v[i]) trace_ok = 0;
    checks++;
    if (trace_ok != 1) begin
      errors++;
      $display("FAIL n1_trace: %0d writes logged or wrong entries, required 7 matching", wlog_addr.size());
    end
    finish_run();
  endtask

  task automatic test_n7();
    int edges;
    int r2_ok = 1;
    int r2_next = 7;
    do_run(4'd7, 1'b0, edges);
    checks++;
    if (edges != 33) begin
      errors++;
      $display("FAIL n7_latency: got %0d edges, required 33", edges);
    end
    @(negedge Clk);
    #1;
    checks++;
    if (data_out !== 4'd13) begin
      errors++;
      $display("FAIL n7_result: data_out=%0d, required 13", data_out);
    end
    for (int i = 0; i < wlog_addr.size(); i++)
      if (wlog_addr[i] == 2) begin
        if (wlog_val[i] != r2_next) r2_ok = 0;
        r2_next--;
      end
    checks++;
    if (r2_ok != 1 || r2_next != -1) begin
      errors++;
      $display("FAIL n7_r2_count: R2 sequence broken (next=%0d), required 7 down to 0", r2_next);
    end
    finish_run();
  endtask

  task automatic test_wrap();
    int edges;
    do_run(4'd8, 1'b0, edges);
    checks++;
    if (edges != 37) begin
      errors++;
      $display("FAIL n8_latency: got %0d edges, required 37", edges);
    end
    @(negedge Clk);
    #1;
    checks++;
    if (data_out !== 4'd5) begin
      errors++;
      $display("FAIL n8_result: data_out=%0d, required 5", data_out);
    end
    finish_run();
    do_run(4'd15, 1'b0, edges);
    checks++;
    if (edges != 65) begin
      errors++;
      $display("FAIL n15_latency: got %0d edges, required 65", edges);
    end
    @(negedge Clk);
    #1;
    checks++;
    if (data_out !== 4'd2) begin
      errors++;
      $display("FAIL n15_result: data_out=%0d, required 2", data_out);
    end
    finish_run();
  endtask

  task automatic test_midrun_reset();
    int edges;
    @(negedge Clk);
    start = 1'b1;
    n_in  = 4'd7;
    @(posedge Clk);
    repeat (11) @(posedge Clk);
    @(negedge Clk);
    Rst   = 1'b1;
    start = 1'b0;
    @(posedge Clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || wrt_en !== 1'b0) begin
      errors++;
      $display("FAIL abort_flags: busy=%b done=%b wrt_en=%b, required 0/0/0", busy, done, wrt_en);
    end
    @(negedge Clk);
    Rst = 1'b0;
    do_run(4'd5, 1'b0, edges);
    checks++;
    if (edges != 25) begin
      errors++;
      $display("FAIL rerun_latency: got %0d edges, required 25", edges);
    end
    @(negedge Clk);
    #1;
    checks++;
    if (data_out !== 4'd5) begin
      errors++;
      $display("FAIL rerun_result: data_out=%0d, required 5", data_out);
    end
    finish_run();
  endtask

  task automatic test_handshake();
    int edges;
    int held_ok = 1;
    do_run(4'd3, 1'b0, edges);
    for (int k = 0; k < 6; k++) begin
      @(posedge Clk);
      #1;
      if (done !== 1'b1 || busy !== 1'b0 || wrt_en !== 1'b0) held_ok = 0;
    end
    checks++;
    if (held_ok != 1) begin
      errors++;
      $display("FAIL hold_done: done=%b busy=%b, required done held high while start high", done, busy);
    end
    checks++;
    if (data_out !== 4'd2) begin
      errors++;
      $display("FAIL hold_result: data_out=%0d, required 2", data_out);
    end
    finish_run();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL release_idle: done=%b busy=%b, required 0/0", done, busy);
    end
    do_run(4'd2, 1'b1, edges);
    checks++;
    if (edges != 13) begin
      errors++;
      $display("FAIL n2_latency: got %0d edges, required 13", edges);
    end
    @(negedge Clk);
    #1;
    checks++;
    if (data_out !== 4'd1) begin
      errors++;
      $display("FAIL n2_result: data_out=%0d, required 1", data_out);
    end
    finish_run();
    repeat (2) @(negedge Clk);
    #1;
    checks++;
    if (data_out !== 4'd1) begin
      errors++;
      $display("FAIL idle_result: data_out=%0d, required 1 after done falls", data_out);
    end
  endtask

  initial begin
    Rst   = 1'b1;
    start = 1'b0;
    n_in  = '0;
    test_reset();
    test_n0();
    test_n1_trace();
    test_n7();
    test_wrap();
    test_midrun_reset();
    test_handshake();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
